// File: rtl/ram_rr_access_arbiter_if.sv
// Bus bundle for the RAM round-robin arbiter: requester commands, one RAM port and
// the tagged read-response stream. slave = arbiter view, master = environment view.
interface ram_rr_access_arbiter_if #(
  parameter int NUM   = 4,
  parameter int DSIZE = 32,
  parameter int ASIZE = 12
);
  localparam int CW  = DSIZE + ASIZE + 1;
  localparam int IDW = $clog2(NUM);

  logic [NUM-1:0]         req_valid;
  logic [NUM*CW-1:0]      req_data;
  logic [NUM-1:0]         req_ready;
  logic                   ram_en;
  logic                   ram_we;
  logic [ASIZE-1:0]       ram_addr;
  logic [DSIZE-1:0]       ram_din;
  logic [DSIZE-1:0]       ram_dout;
  logic                   rsp_valid;
  logic [DSIZE+ASIZE-1:0] rsp_data;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_ready;

  modport slave (
    input  req_valid, req_data, ram_dout, rsp_ready,
    output req_ready, ram_en, ram_we, ram_addr, ram_din, rsp_valid, rsp_data, rsp_id
  );

  modport master (
    output req_valid, req_data, ram_dout, rsp_ready,
    input  req_ready, ram_en, ram_we, ram_addr, ram_din, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/ram_rr_access_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM requesters; reads are tracked
// through a latency tag pipeline and returned via a credit-protected FWFT response FIFO.
module ram_rr_access_arbiter #(
  parameter int NUM       = 4,
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 12,
  parameter int RD_LAT    = 3,
  parameter int RSP_DEPTH = 8
) (
  input logic               clock,
  input logic               rst_n,
  ram_rr_access_arbiter_if.slave bus
);
  localparam int CW  = DSIZE + ASIZE + 1;
  localparam int IDW = $clog2(NUM);
  localparam int PW  = $clog2(RSP_DEPTH);
  localparam int CRW = PW + 1;
  localparam int RW  = IDW + ASIZE + DSIZE;

  logic [CW-1:0]    cmd [NUM];
  logic [NUM-1:0]   eligible;
  logic [CRW-1:0]   credits;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cand;
  logic [IDW-1:0]   grant_idx;
  logic             grant_valid;
  logic [CW-1:0]    grant_cmd;
  logic             grant_we;
  logic             hs;
  logic             rd_hs;
  logic             pop;

  logic             ram_en_q;
  logic             ram_we_q;
  logic [ASIZE-1:0] ram_addr_q;
  logic [DSIZE-1:0] ram_din_q;
  logic [IDW-1:0]   issue_id;

  logic             pipe_v    [RD_LAT];
  logic [IDW-1:0]   pipe_id   [RD_LAT];
  logic [ASIZE-1:0] pipe_addr [RD_LAT];

  logic [RW-1:0]    fifo_mem [RSP_DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             fifo_wr;
  logic             fifo_full;
  logic             rsp_valid;
  logic [RW-1:0]    fifo_head;

  // A read is only eligible while a response slot is reserved for it.
  for (genvar i = 0; i < NUM; i++) begin : g_req
    assign cmd[i]      = bus.req_data[i*CW +: CW];
    assign eligible[i] = bus.req_valid[i] & (cmd[i][CW-1] | (credits != '0));
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign grant_cmd     = cmd[grant_idx];
  assign grant_we      = grant_cmd[CW-1];
  assign hs            = grant_valid & rst_n;
  assign rd_hs         = hs & ~grant_we;
  assign pop           = rsp_valid & bus.rsp_ready;
  assign bus.req_ready = hs ? (NUM'(1) << grant_idx) : '0;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= IDW'(NUM - 1);
      ram_en_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      issue_id   <= '0;
    end else begin
      ram_en_q <= hs;
      ram_we_q <= hs & grant_we;
      if (hs) begin
        rr_ptr     <= grant_idx;
        issue_id   <= grant_idx;
        ram_addr_q <= grant_cmd[DSIZE +: ASIZE];
        ram_din_q  <= grant_cmd[DSIZE-1:0];
      end
    end
  end

  assign bus.ram_en   = ram_en_q;
  assign bus.ram_we   = ram_we_q;
  assign bus.ram_addr = ram_addr_q;
  assign bus.ram_din  = ram_din_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      credits <= CRW'(RSP_DEPTH);
    end else begin
      case ({rd_hs, pop})
        2'b10:   credits <= credits - CRW'(1);
        2'b01:   credits <= credits + CRW'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Stage RD_LAT-1 lines up with the cycle the RAM presents the read data.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipe_v[s]    <= 1'b0;
        pipe_id[s]   <= '0;
        pipe_addr[s] <= '0;
      end
    end else begin
      pipe_v[0]    <= ram_en_q & ~ram_we_q;
      pipe_id[0]   <= issue_id;
      pipe_addr[0] <= ram_addr_q;
      for (int s = 1; s < RD_LAT; s++) begin
        pipe_v[s]    <= pipe_v[s-1];
        pipe_id[s]   <= pipe_id[s-1];
        pipe_addr[s] <= pipe_addr[s-1];
      end
    end
  end

  assign fifo_wr = pipe_v[RD_LAT-1];

  always_ff @(posedge clock) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {pipe_id[RD_LAT-1], pipe_addr[RD_LAT-1], bus.ram_dout};
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign fifo_full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign rsp_valid     = (wr_ptr != rd_ptr);
  assign fifo_head     = fifo_mem[rd_ptr[PW-1:0]];
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_valid ? fifo_head[ASIZE+DSIZE-1:0] : '0;
  assign bus.rsp_id    = rsp_valid ? fifo_head[RW-1 -: IDW] : '0;

  credits_max: assert property (@(posedge clock) disable iff (!rst_n)
    credits <= CRW'(RSP_DEPTH));
  credits_underflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(rd_hs && credits == '0));
  fifo_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(fifo_wr && fifo_full));
endmodule

// File: tb/tb_ram_rr_access_arbiter.sv
// Self-checking bench: behavioural RAM, transaction-level arbiter model with an
// expected-response queue, plus directed scenarios with literal expectations.
module tb_ram_rr_access_arbiter;
  localparam int NUM       = 4;
  localparam int DSIZE     = 32;
  localparam int ASIZE     = 12;
  localparam int RD_LAT    = 3;
  localparam int RSP_DEPTH = 8;
  localparam int CW        = DSIZE + ASIZE + 1;

  logic clock;
  logic rst_n;

  ram_rr_access_arbiter_if #(.NUM(NUM), .DSIZE(DSIZE), .ASIZE(ASIZE)) bus ();

  ram_rr_access_arbiter #(
    .NUM(NUM), .DSIZE(DSIZE), .ASIZE(ASIZE), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  logic [31:0] bram    [4096];
  logic [31:0] rd_pipe [RD_LAT];

  // Behavioural RAM: a read issued in cycle T shows up on ram_dout in cycle T+RD_LAT.
  always @(posedge clock) begin
    if (bus.ram_en && bus.ram_we) bram[bus.ram_addr] <= bus.ram_din;
    rd_pipe[0] <= (bus.ram_en && !bus.ram_we) ? bram[bus.ram_addr] : 32'h0BAD0BAD;
    for (int s = 1; s < RD_LAT; s++) rd_pipe[s] <= rd_pipe[s-1];
  end
  assign bus.ram_dout = rd_pipe[RD_LAT-1];

  typedef struct {
    int          id;
    logic [11:0] addr;
    logic [31:0] data;
    int          avail;
  } rsp_t;

  rsp_t        mq[$];
  int          m_ptr;
  int          m_credits;
  logic        m_en;
  logic        m_we;
  logic [11:0] m_addr;
  logic [31:0] m_din;
  logic [31:0] m_mem [4096];
  int          cyc = 0;

  int          grant_log[$];
  int          rspid_log[$];
  logic [31:0] rspdata_log[$];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int i, input bit v, input bit we,
                                input logic [11:0] a, input logic [31:0] d);
    bus.req_valid[i]          = v;
    bus.req_data[i*CW +: CW]  = {we, a, d};
  endtask

  task automatic clear_all();
    bus.req_valid = '0;
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  // Cycle model: arbitration from the current inputs, then commit its effects.
  always @(negedge clock) begin : model_compare
    int          g;
    int          idx;
    logic [NUM-1:0] exp_ready;
    bit          exp_v;
    logic [CW-1:0] c;
    rsp_t        e;
    cyc++;
    if (!rst_n) begin
      check_output("rst_req_ready", 64'(bus.req_ready), 64'(0));
      check_output("rst_ram_en",    64'(bus.ram_en),    64'(0));
      check_output("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
      check_output("rst_rsp_data",  64'(bus.rsp_data),  64'(0));
      m_ptr     = NUM - 1;
      m_credits = RSP_DEPTH;
      m_en      = 1'b0;
      m_we      = 1'b0;
      m_addr    = '0;
      m_din     = '0;
      mq.delete();
    end else begin
      g = -1;
      for (int k = 1; k <= NUM; k++) begin
        idx = (m_ptr + k) % NUM;
        c   = bus.req_data[idx*CW +: CW];
        if (g < 0 && bus.req_valid[idx] && (c[CW-1] || m_credits > 0)) g = idx;
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check_output("req_ready", 64'(bus.req_ready), 64'(exp_ready));
      check_output("ram_en",    64'(bus.ram_en),    64'(m_en));
      check_output("ram_we",    64'(bus.ram_we),    64'(m_we));
      check_output("ram_addr",  64'(bus.ram_addr),  64'(m_addr));
      check_output("ram_din",   64'(bus.ram_din),   64'(m_din));
      exp_v = (mq.size() > 0) && (mq[0].avail <= cyc);
      check_output("rsp_valid", 64'(bus.rsp_valid), 64'(exp_v));
      if (exp_v) begin
        check_output("rsp_data", 64'(bus.rsp_data), 64'({mq[0].addr, mq[0].data}));
        check_output("rsp_id",   64'(bus.rsp_id),   64'(mq[0].id));
      end
      for (int i = 0; i < NUM; i++) if (bus.req_ready[i]) grant_log.push_back(i);
      if (bus.rsp_valid && bus.rsp_ready) begin
        rspid_log.push_back(int'(bus.rsp_id));
        rspdata_log.push_back(bus.rsp_data[31:0]);
      end
      if (exp_v && bus.rsp_ready) begin
        void'(mq.pop_front());
        m_credits++;
      end
      if (g >= 0) begin
        c      = bus.req_data[g*CW +: CW];
        m_ptr  = g;
        m_en   = 1'b1;
        m_we   = c[CW-1];
        m_addr = c[DSIZE +: ASIZE];
        m_din  = c[DSIZE-1:0];
        if (c[CW-1]) begin
          m_mem[m_addr] = m_din;
        end else begin
          m_credits--;
          e.id    = g;
          e.addr  = m_addr;
          e.data  = m_mem[m_addr];
          e.avail = cyc + RD_LAT + 2;
          mq.push_back(e);
        end
      end else begin
        m_en = 1'b0;
        m_we = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    clear_all();
    advance();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic count_grants(input int who, output int n);
    n = 0;
    foreach (grant_log[i]) if (grant_log[i] == who) n++;
  endtask

  initial begin : stimulus
    int n;
    for (int a = 0; a < 4096; a++) begin
      bram[a]  = '0;
      m_mem[a] = '0;
    end
    for (int s = 0; s < RD_LAT; s++) rd_pipe[s] = '0;
    rst_n         = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;

    // Request pending during reset must not be accepted.
    apply_stimulus(0, 1'b1, 1'b0, 12'h000, 32'h0);
    sample();
    check_output("reset_req_ready", 64'(bus.req_ready), 64'(0));
    check_output("reset_ram_en",    64'(bus.ram_en),    64'(0));
    advance();
    advance();
    clear_all();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // Single write then read-back with exact latency.
    apply_stimulus(0, 1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    sample();
    check_output("wr_req_ready", 64'(bus.req_ready), 64'(4'b0001));
    advance();
    clear_all();
    sample();
    check_output("wr_ram_en",   64'(bus.ram_en),   64'(1));
    check_output("wr_ram_we",   64'(bus.ram_we),   64'(1));
    check_output("wr_ram_addr", 64'(bus.ram_addr), 64'(12'h010));
    check_output("wr_ram_din",  64'(bus.ram_din),  64'(32'hDEADBEEF));
    advance();
    apply_stimulus(0, 1'b1, 1'b0, 12'h010, 32'h0);
    sample();
    check_output("rd_req_ready", 64'(bus.req_ready), 64'(4'b0001));
    advance();
    clear_all();
    for (int d = 1; d <= RD_LAT + 1; d++) begin
      sample();
      check_output("rd_early_valid", 64'(bus.rsp_valid), 64'(0));
      advance();
    end
    sample();
    check_output("rd_lat_valid", 64'(bus.rsp_valid), 64'(1));
    check_output("rd_lat_data",  64'(bus.rsp_data),  64'({12'h010, 32'hDEADBEEF}));
    check_output("rd_lat_id",    64'(bus.rsp_id),    64'(0));
    advance();

    // All requesters read continuously: strict rotation starting at 0.
    do_reset();
    bus.rsp_ready = 1'b1;
    grant_log.delete();
    rspid_log.delete();
    for (int i = 0; i < NUM; i++) apply_stimulus(i, 1'b1, 1'b0, 12'(12'h300 + i), 32'h0);
    for (int c = 0; c < 12; c++) begin
      sample();
      advance();
    end
    clear_all();
    for (int c = 0; c < 12; c++) begin
      sample();
      advance();
    end
    check_output("rr_grant_count", 64'(grant_log.size()), 64'(12));
    check_output("rr_rsp_count",   64'(rspid_log.size()), 64'(12));
    for (int k = 0; k < 12 && k < grant_log.size() && k < rspid_log.size(); k++) begin
      check_output("rr_grant_order", 64'(grant_log[k]), 64'(k % 4));
      check_output("rr_rsp_order",   64'(rspid_log[k]), 64'(k % 4));
    end

    // Credit exhaustion with stalled responses; a write still gets through.
    bus.rsp_ready = 1'b0;
    grant_log.delete();
    apply_stimulus(2, 1'b1, 1'b0, 12'h010, 32'h0);
    for (int c = 0; c < 14; c++) begin
      if (c == 11) apply_stimulus(1, 1'b1, 1'b1, 12'h020, 32'hCAFE0001);
      sample();
      if (c == 11) check_output("credit_write_grant", 64'(bus.req_ready), 64'(4'b0010));
      if (c == 12) check_output("credit_read_block",  64'(bus.req_ready), 64'(4'b0000));
      advance();
      if (c == 11) apply_stimulus(1, 1'b0, 1'b1, 12'h020, 32'hCAFE0001);
    end
    count_grants(2, n);
    check_output("credit_read_count", 64'(n), 64'(RSP_DEPTH));
    rspid_log.delete();
    rspdata_log.delete();
    bus.rsp_ready = 1'b1;
    sample();
    check_output("drain_first_valid", 64'(bus.rsp_valid), 64'(1));
    check_output("drain_no_read_yet", 64'(bus.req_ready[2]), 64'(0));
    advance();
    sample();
    check_output("drain_read_resume", 64'(bus.req_ready[2]), 64'(1));
    advance();
    clear_all();
    for (int c = 0; c < 14; c++) begin
      sample();
      advance();
    end
    check_output("drain_rsp_count", 64'(rspid_log.size()), 64'(RSP_DEPTH + 1));
    foreach (rspid_log[k]) begin
      check_output("drain_rsp_id",   64'(rspid_log[k]),   64'(2));
      check_output("drain_rsp_data", 64'(rspdata_log[k]), 64'(32'hDEADBEEF));
    end

    // Alternating write/read to one address from requester 1.
    rspdata_log.delete();
    for (int k = 0; k < 6; k++) begin
      apply_stimulus(1, 1'b1, 1'b1, 12'h055, 32'(32'h100 + k));
      sample();
      advance();
      apply_stimulus(1, 1'b1, 1'b0, 12'h055, 32'h0);
      sample();
      advance();
    end
    clear_all();
    for (int c = 0; c < 10; c++) begin
      sample();
      advance();
    end
    check_output("raw_rsp_count", 64'(rspdata_log.size()), 64'(6));
    foreach (rspdata_log[k]) check_output("raw_rsp_data", 64'(rspdata_log[k]), 64'(32'h100 + k));

    // Reset with two responses queued and three reads still in the RAM.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      clear_all();
      apply_stimulus(k % 4, 1'b1, 1'b0, 12'h055, 32'h0);
      sample();
      advance();
    end
    clear_all();
    sample();
    advance();
    apply_stimulus(0, 1'b1, 1'b0, 12'h055, 32'h0);
    check_output("pre_reset_valid", 64'(bus.rsp_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_req_ready", 64'(bus.req_ready), 64'(0));
    check_output("async_ram_en",    64'(bus.ram_en),    64'(0));
    check_output("async_ram_addr",  64'(bus.ram_addr),  64'(0));
    check_output("async_ram_din",   64'(bus.ram_din),   64'(0));
    check_output("async_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check_output("async_rsp_data",  64'(bus.rsp_data),  64'(0));
    check_output("async_rsp_id",    64'(bus.rsp_id),    64'(0));
    advance();
    advance();
    clear_all();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    rspid_log.delete();
    for (int c = 0; c < 10; c++) begin
      sample();
      advance();
    end
    check_output("post_reset_no_rsp", 64'(rspid_log.size()), 64'(0));
    bus.rsp_ready = 1'b0;
    grant_log.delete();
    apply_stimulus(3, 1'b1, 1'b0, 12'h055, 32'h0);
    for (int c = 0; c < 12; c++) begin
      sample();
      advance();
    end
    count_grants(3, n);
    check_output("post_reset_credits", 64'(n), 64'(RSP_DEPTH));
    clear_all();
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      sample();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_rr_access_arbiter.md
Name: ram_rr_access_arbiter

Overview:
- Shares one port of a common dual-port RAM between NUM requesters.
- Each requester presents a read/write command stream of {we, addr, wdata}, the same packing as the existing single-requester RAM front-end.
- The block round-robin arbitrates commands, drives the RAM port, tracks read latency with a tag pipeline and returns read data through a credit-protected response FIFO tagged with requester id.
- It sits between several ld/st engines and the cm_ram_inf port B of the lookup RAM.

Parameters:
- NUM, 4, number of requesters (2..8)
- DSIZE, 32, RAM data width
- ASIZE, 12, RAM address width
- RD_LAT, 3, RAM read latency in clocks from en&~we to valid dout (1..8)
- RSP_DEPTH, 8, response FIFO depth, power of two, >= RD_LAT

Ports:
- clock  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM  per-requester command valid
- req_data  in  NUM*(DSIZE+ASIZE+1)  per-requester command, slice i = {we[MSB], addr, wdata[DSIZE-1:0]}
- req_ready  out  NUM  per-requester command accept
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ASIZE  RAM address
- ram_din  out  DSIZE  RAM write data
- ram_dout  in  DSIZE  RAM read data
- rsp_valid  out  1  read response valid
- rsp_data  out  DSIZE+ASIZE  read response {addr, rdata}
- rsp_id  out  $clog2(NUM)  requester index of the response
- rsp_ready  in  1  response accept

Behaviour:
- Async reset: req_ready=0, ram_en=0, ram_we=0, ram_addr=0, ram_din=0, rsp_valid=0, rsp_data=0, rsp_id=0. Round-robin pointer=NUM-1, so requester 0 has first priority. credits=RSP_DEPTH. Tag pipeline and FIFO are empty.
- Eligibility: requester i is eligible when req_valid[i] is high and either we=1, or we=0 and credits>0.
- Arbitration: each cycle, grant the first eligible requester scanning from pointer+1 modulo NUM. At most one grant per cycle. On a grant the pointer becomes the granted index; with no grant the pointer holds. Ineligible requesters (reads blocked by credits) are skipped, so writes still proceed.
- req_ready[i] is combinational: high only for the granted index. A handshake occurs in the same cycle.
- RAM drive: registered, 1-cycle issue latency. In the cycle after a handshake, ram_en=1, ram_we=we, and ram_addr/ram_din come from the command. Otherwise ram_en=0, ram_we=0, and addr/din hold.
- Read tracking: a read issue pushes {valid, id, addr} into a RD_LAT-stage shift pipeline aligned with ram_dout. At the pipeline output, a valid entry writes {addr, ram_dout} and id into the response FIFO unconditionally; credits guarantee space.
- Credits:
  - Decrement by 1 on a read handshake.
  - Increment by 1 on rsp_valid&rsp_ready.
  - Simultaneous read handshake and response pop leave credits unchanged.
  - credits never exceeds RSP_DEPTH and never underflows; both are assertion-checked.
- Response: FIFO output is first-word-fall-through. rsp_valid = FIFO non-empty. rsp_data/rsp_id are stable while rsp_valid&~rsp_ready.
- Latency: read handshake to rsp_valid is RD_LAT+2 clocks with an empty FIFO (1 issue reg + RD_LAT + 1 FIFO write).
- Ordering: responses return in global issue order, and therefore in per-requester issue order.
- Writes produce no response and consume no credit.
- Read-after-write to the same address from any requester returns the new data; the RAM port serialises them.
- Wrap: FIFO pointers are $clog2(RSP_DEPTH)+1 bits wide. full = MSB differs and the rest is equal.
- Reset mid-operation discards in-flight reads and FIFO contents. No response is emitted after reset release.

Test Plan:
- Reset release, req0 write {we=1, addr=0x010, wdata=0xDEADBEEF} -> req_ready[0]=1 same cycle. Next cycle ram_en=1, ram_we=1, ram_addr=0x010, ram_din=0xDEADBEEF. No rsp_valid ever.
- Then req0 read addr 0x010 with rsp_ready=1 -> rsp_valid exactly RD_LAT+2 (=5) clocks after the handshake, rsp_data={0x010,0xDEADBEEF}, rsp_id=0.
- All four requesters hold read valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1… one per cycle; rsp_id sequence matches the grant order.
- rsp_ready=0, requester 2 streams reads -> exactly RSP_DEPTH (8) reads accepted, then req_ready[2]=0. A concurrent requester-1 write is still granted. Raising rsp_ready drains 8 responses in order, and reads resume one cycle after the first pop.
- Mixed: requester 1 alternates write/read to the same address with incrementing data, other requesters idle -> each read response returns the data of the immediately preceding write.
- Assert rst_n low while 3 reads are in flight and the FIFO holds 2 -> all outputs at reset values asynchronously. After release, credits=8 and no stale rsp_valid.
